// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution logic: branch kinds, condition
// codes, branch FSM states and NZCV flag bit positions.
package branch_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_B    = 2'b01,
        BR_CBZ  = 2'b10,
        BR_COND = 2'b11
    } brType_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] packNzcv(input logic n, input logic z,
                                            input logic c, input logic v);
        return {n, z, c, v};
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Pure combinational condition-code evaluator: (cond, NZCV) -> taken.
// Reusable by any branch or conditional-select logic.
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       taken
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        taken = 1'b0;
        case (cond_e'(cond))
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_HS: taken = c;
            COND_LO: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c & !z;
            COND_LS: taken = !c | z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z & (n == v);
            COND_LE: taken = z | (n != v);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// NZCV flag register plus registered B / CBZ / B.cond resolution with a
// multi-cycle flush. Optional macro FLAG_FORWARD_EN bypasses ALU flags to B.cond.
module flag_branch_unit
    import branch_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exValid,
    input  logic              setFlags,
    input  logic              aluNeg,
    input  logic              aluZero,
    input  logic              aluOvf,
    input  logic              aluCarry,
    input  logic              brValid,
    input  logic [1:0]        brType,
    input  logic [3:0]        brCond,
    input  logic              regZero,
    input  logic [ADDR_W-1:0] brTarget,
    output logic              stall,
    output logic              branchTaken,
    output logic [ADDR_W-1:0] branchTarget,
    output logic              flush,
    output logic [3:0]        flags
);

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_e      state, nextState;
    brType_e     reqType;
    logic [2:0]  flushCount;
    logic [3:0]  flagReg, aluFlags, condFlags;
    logic        flagWrite, condTaken, decision, accept, takeBranch;

    assign reqType   = brType_e'(brType);
    assign aluFlags  = packNzcv(aluNeg, aluZero, aluCarry, aluOvf);
    assign flagWrite = exValid & setFlags;
    assign flags     = flagReg;

`ifdef FLAG_FORWARD_EN
    assign condFlags = flagWrite ? aluFlags : flagReg;
    assign stall     = 1'b0;
`else
    // Hold a B.cond that races its own flag write so it resolves next cycle
    // against the freshly written register.
    logic hazard;
    assign hazard    = flagWrite & brValid & (reqType == BR_COND);
    assign condFlags = flagReg;
    assign stall     = hazard & (state == IDLE) & reset;
`endif

    cond_eval uCondEval (
        .cond  (brCond),
        .nzcv  (condFlags),
        .taken (condTaken)
    );

    always_comb begin
        decision = 1'b0;
        case (reqType)
            BR_B:    decision = 1'b1;
            BR_CBZ:  decision = regZero;
            BR_COND: decision = condTaken;
            default: decision = 1'b0;
        endcase
    end

    assign accept     = brValid & (reqType != BR_NONE) & !stall & (state == IDLE);
    assign takeBranch = accept & decision;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (takeBranch) nextState = FLUSH;
            FLUSH:   if (flushCount == 3'd0) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        flush = (state == FLUSH);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            branchTaken  <= 1'b0;
            branchTarget <= '0;
            flushCount   <= 3'd0;
        end else begin
            branchTaken <= takeBranch;
            if (takeBranch) begin
                branchTarget <= brTarget;
                flushCount   <= CNT_INIT;
            end else if (state == FLUSH && flushCount != 3'd0) begin
                flushCount <= flushCount - 3'd1;
            end
        end
    end

    // Flag writes land even while flushing; squashing EX is the pipeline's job.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flagReg <= 4'b0000;
        end else if (flagWrite) begin
            flagReg <= aluFlags;
        end
    end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: expected branch results are queued
// when a request is driven and popped on the cycle the decision appears.
module tb_flag_branch_unit;

    localparam int ADDR_W = 64;

    typedef struct {
        logic              taken;
        logic [ADDR_W-1:0] target;
    } exp_t;

    logic              clk, reset;
    logic              exValid, setFlags, aluNeg, aluZero, aluOvf, aluCarry;
    logic              brValid, regZero;
    logic [1:0]        brType;
    logic [3:0]        brCond;
    logic [ADDR_W-1:0] brTarget;
    logic              stall, branchTaken, flush;
    logic [ADDR_W-1:0] branchTarget;
    logic [3:0]        flags;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    flag_branch_unit #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .exValid      (exValid),
        .setFlags     (setFlags),
        .aluNeg       (aluNeg),
        .aluZero      (aluZero),
        .aluOvf       (aluOvf),
        .aluCarry     (aluCarry),
        .brValid      (brValid),
        .brType       (brType),
        .brCond       (brCond),
        .regZero      (regZero),
        .brTarget     (brTarget),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .flush        (flush),
        .flags        (flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Condition table written as base test plus inversion by the low bit.
    function automatic logic condModel(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (cond[0] && cond[3:1] != 3'd7) r = !r;
        return r;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        exValid = 0; setFlags = 0; aluNeg = 0; aluZero = 0; aluOvf = 0; aluCarry = 0;
        brValid = 0; brType = 2'b00; brCond = 4'h0; regZero = 0; brTarget = '0;
    endtask

    task automatic loadFlags(input logic [3:0] nzcv);
        exValid = 1; setFlags = 1;
        aluNeg = nzcv[3]; aluZero = nzcv[2]; aluCarry = nzcv[1]; aluOvf = nzcv[0];
        cycle();
        idleInputs();
    endtask

    task automatic test_reset();
        reset = 0;
        idleInputs();
        cycle();
        cycle();
        vectors++; if (flags !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_flags got %b expected 0000", flags); end
        vectors++; if (branchTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_taken got %b expected 0", branchTaken); end
        vectors++; if (branchTarget !== '0) begin miscompares++; $display("[TB] FAIL reset_target got %h expected 0", branchTarget); end
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_flush got %b expected 0", flush); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall got %b expected 0", stall); end
        reset = 1;
        cycle();
    endtask

    task automatic test_flag_load_eq();
        loadFlags(4'b0100);
        vectors++; if (flags !== 4'b0100) begin miscompares++; $display("[TB] FAIL flag_load got %b expected 0100", flags); end
        brValid = 1; brType = 2'b11; brCond = 4'h0; brTarget = 64'h40;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL eq_stall got %b expected 0", stall); end
        sb.push_back('{taken: 1'b1, target: 64'h40});
        cycle();
        idleInputs();
        e = sb.pop_front();
        vectors++; if (branchTaken !== e.taken) begin miscompares++; $display("[TB] FAIL eq_taken got %b expected %b", branchTaken, e.taken); end
        vectors++; if (branchTarget !== e.target) begin miscompares++; $display("[TB] FAIL eq_target got %h expected %h", branchTarget, e.target); end
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("[TB] FAIL eq_flush1 got %b expected 1", flush); end
        cycle();
        vectors++; if (branchTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL eq_pulse got %b expected 0", branchTaken); end
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("[TB] FAIL eq_flush2 got %b expected 1", flush); end
        cycle();
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL eq_flush_end got %b expected 0", flush); end
    endtask

    task automatic test_cbz();
        brValid = 1; brType = 2'b10; regZero = 0; brTarget = 64'h80;
        sb.push_back('{taken: 1'b0, target: 64'h0});
        cycle();
        idleInputs();
        e = sb.pop_front();
        vectors++; if (branchTaken !== e.taken) begin miscompares++; $display("[TB] FAIL cbz_nt_taken got %b expected %b", branchTaken, e.taken); end
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL cbz_nt_flush got %b expected 0", flush); end
        brValid = 1; brType = 2'b10; regZero = 1; brTarget = 64'h88;
        sb.push_back('{taken: 1'b1, target: 64'h88});
        cycle();
        idleInputs();
        e = sb.pop_front();
        vectors++; if (branchTaken !== e.taken) begin miscompares++; $display("[TB] FAIL cbz_t_taken got %b expected %b", branchTaken, e.taken); end
        vectors++; if (branchTarget !== e.target) begin miscompares++; $display("[TB] FAIL cbz_t_target got %h expected %h", branchTarget, e.target); end
        cycle();
        cycle();
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL cbz_drain got %b expected 0", flush); end
    endtask

    task automatic test_signed();
        logic [3:0] conds[4];
        logic       want[4];
        conds = '{4'hB, 4'hA, 4'hC, 4'hD};
        want  = '{1'b1, 1'b0, 1'b0, 1'b1};
        loadFlags(4'b1000);
        vectors++; if (flags !== 4'b1000) begin miscompares++; $display("[TB] FAIL signed_flags got %b expected 1000", flags); end
        for (int i = 0; i < 4; i++) begin
            brValid = 1; brType = 2'b11; brCond = conds[i]; brTarget = 64'h1000 + 64'(i);
            sb.push_back('{taken: want[i], target: 64'h1000 + 64'(i)});
            cycle();
            idleInputs();
            e = sb.pop_front();
            vectors++; if (branchTaken !== e.taken) begin miscompares++; $display("[TB] FAIL signed_cond%h got %b expected %b", conds[i], branchTaken, e.taken); end
            if (e.taken) begin
                vectors++; if (branchTarget !== e.target) begin miscompares++; $display("[TB] FAIL signed_target%h got %h expected %h", conds[i], branchTarget, e.target); end
                cycle();
                cycle();
            end
        end
    endtask

    task automatic test_all_conds();
        logic [3:0] pats[6];
        pats = '{4'b0000, 4'b0100, 4'b0010, 4'b0001, 4'b0110, 4'b1001};
        for (int p = 0; p < 6; p++) begin
            loadFlags(pats[p]);
            vectors++; if (flags !== pats[p]) begin miscompares++; $display("[TB] FAIL cond_flags got %b expected %b", flags, pats[p]); end
            for (int c = 0; c < 16; c++) begin
                brValid = 1; brType = 2'b11; brCond = 4'(c);
                brTarget = {56'h0, pats[p], 4'(c)};
                sb.push_back('{taken: condModel(4'(c), pats[p]), target: {56'h0, pats[p], 4'(c)}});
                cycle();
                idleInputs();
                e = sb.pop_front();
                vectors++; if (branchTaken !== e.taken) begin miscompares++; $display("[TB] FAIL cond_%b_%h got %b expected %b", pats[p], c, branchTaken, e.taken); end
                if (e.taken) begin
                    vectors++; if (branchTarget !== e.target) begin miscompares++; $display("[TB] FAIL cond_tgt_%b_%h got %h expected %h", pats[p], c, branchTarget, e.target); end
                end
                if (branchTaken === 1'b1) begin
                    cycle();
                    cycle();
                end
            end
        end
    endtask

    task automatic test_hazard();
        loadFlags(4'b0000);
        exValid = 1; setFlags = 1; aluZero = 1;
        brValid = 1; brType = 2'b11; brCond = 4'h0; brTarget = 64'h100;
        #1;
`ifdef FLAG_FORWARD_EN
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL hazard_stall got %b expected 0", stall); end
        sb.push_back('{taken: 1'b1, target: 64'h100});
        cycle();
        idleInputs();
`else
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL hazard_stall got %b expected 1", stall); end
        sb.push_back('{taken: 1'b0, target: 64'h0});
        cycle();
        exValid = 0; setFlags = 0; aluZero = 0;
        e = sb.pop_front();
        vectors++; if (branchTaken !== e.taken) begin miscompares++; $display("[TB] FAIL hazard_hold got %b expected %b", branchTaken, e.taken); end
        vectors++; if (flags !== 4'b0100) begin miscompares++; $display("[TB] FAIL hazard_flags got %b expected 0100", flags); end
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL hazard_release got %b expected 0", stall); end
        sb.push_back('{taken: 1'b1, target: 64'h100});
        cycle();
        idleInputs();
`endif
        e = sb.pop_front();
        vectors++; if (branchTaken !== e.taken) begin miscompares++; $display("[TB] FAIL hazard_taken got %b expected %b", branchTaken, e.taken); end
        vectors++; if (branchTarget !== e.target) begin miscompares++; $display("[TB] FAIL hazard_target got %h expected %h", branchTarget, e.target); end
        cycle();
        cycle();
    endtask

    task automatic test_back_to_back();
        brValid = 1; brType = 2'b01; brTarget = 64'h200;
        sb.push_back('{taken: 1'b1, target: 64'h200});
        cycle();
        brTarget = 64'h300;
        e = sb.pop_front();
        vectors++; if (branchTaken !== e.taken) begin miscompares++; $display("[TB] FAIL b2b_first got %b expected %b", branchTaken, e.taken); end
        vectors++; if (branchTarget !== e.target) begin miscompares++; $display("[TB] FAIL b2b_first_tgt got %h expected %h", branchTarget, e.target); end
        cycle();
        vectors++; if (branchTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_ignored1 got %b expected 0", branchTaken); end
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_flush2 got %b expected 1", flush); end
        cycle();
        vectors++; if (branchTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_ignored2 got %b expected 0", branchTaken); end
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_idle got %b expected 0", flush); end
        brTarget = 64'h400;
        sb.push_back('{taken: 1'b1, target: 64'h400});
        cycle();
        idleInputs();
        e = sb.pop_front();
        vectors++; if (branchTaken !== e.taken) begin miscompares++; $display("[TB] FAIL b2b_next got %b expected %b", branchTaken, e.taken); end
        vectors++; if (branchTarget !== e.target) begin miscompares++; $display("[TB] FAIL b2b_next_tgt got %h expected %h", branchTarget, e.target); end
        cycle();
        cycle();
    endtask

    task automatic test_reset_mid_flush();
        loadFlags(4'b1011);
        brValid = 1; brType = 2'b01; brTarget = 64'h500;
        sb.push_back('{taken: 1'b1, target: 64'h500});
        cycle();
        idleInputs();
        e = sb.pop_front();
        vectors++; if (branchTaken !== e.taken) begin miscompares++; $display("[TB] FAIL rmf_taken got %b expected %b", branchTaken, e.taken); end
        cycle();
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("[TB] FAIL rmf_flush2 got %b expected 1", flush); end
        reset = 0;
        cycle();
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("[TB] FAIL rmf_flush got %b expected 0", flush); end
        vectors++; if (flags !== 4'b0000) begin miscompares++; $display("[TB] FAIL rmf_flags got %b expected 0000", flags); end
        vectors++; if (branchTaken !== 1'b0) begin miscompares++; $display("[TB] FAIL rmf_pulse got %b expected 0", branchTaken); end
        reset = 1;
        brValid = 1; brType = 2'b10; regZero = 1; brTarget = 64'h600;
        sb.push_back('{taken: 1'b1, target: 64'h600});
        cycle();
        idleInputs();
        e = sb.pop_front();
        vectors++; if (branchTaken !== e.taken) begin miscompares++; $display("[TB] FAIL rmf_idle got %b expected %b", branchTaken, e.taken); end
        vectors++; if (branchTarget !== e.target) begin miscompares++; $display("[TB] FAIL rmf_idle_tgt got %h expected %h", branchTarget, e.target); end
        cycle();
        cycle();
    endtask

    initial begin
        reset = 0;
        idleInputs();
        test_reset();
        test_flag_load_eq();
        test_cbz();
        test_signed();
        test_all_conds();
        test_hazard();
        test_back_to_back();
        test_reset_mid_flush();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_leftover got %0d expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
